// File: rtl/pcl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and constants for the program-counter slice.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

    // Handshake state toward the PCH byte
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CARRY_REQ  = 2'd1,
        BORROW_REQ = 2'd2,
        RELEASE    = 2'd3
    } pcl_state_t;

    // Low byte of the reset vector fetch address
    localparam logic [7:0] RESET_PCL_DEFAULT = 8'hFC;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pcl_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcl_sequencer_if
//  Description : Decode/PCH-facing signal bundle of the PCL sequencer.
//                master = decode/PCH side, slave = the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface pcl_sequencer_if;
    logic       pcl_load;
    logic [7:0] db_in;
    logic       inc_req;
    logic       branch_req;
    logic [7:0] branch_offset;
    logic       carry_done;
    logic [7:0] db_out;
    logic [7:0] address_low_out;
    logic       carry_to_pch;
    logic       borrow_to_pch;
    logic       busy;
    logic       hs_error;

    modport master (
        output pcl_load, db_in, inc_req, branch_req, branch_offset, carry_done,
        input  db_out, address_low_out, carry_to_pch, borrow_to_pch, busy, hs_error
    );

    modport slave (
        input  pcl_load, db_in, inc_req, branch_req, branch_offset, carry_done,
        output db_out, address_low_out, carry_to_pch, borrow_to_pch, busy, hs_error
    );
endinterface : pcl_sequencer_if
`default_nettype wire

// File: rtl/pcl_sequencer_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pcl_adder
//  Description : PCL adder. Increment (operand=1) or signed branch offset,
//                with page-crossing detection toward PCH.
//  Revision    : 1.0  initial release
// ============================================================================
module pcl_adder (
    input  wire logic [7:0] pcl,
    input  wire logic [7:0] operand,
    input  wire logic       is_branch,
    output logic      [7:0] sum,
    output logic            page_fwd,
    output logic            page_bwd
);

    logic [8:0] sum9;

    // Unsigned 9-bit add; the carry bit is interpreted by the operand sign
    always_comb begin
        sum9 = {1'b0, pcl} + {1'b0, operand};
        sum  = sum9[7:0];
        if (is_branch) begin
            // Positive offset with carry-out steps forward; negative offset
            // without carry-out means the add wrapped below the page start.
            page_fwd = ~operand[7] & sum9[8];
            page_bwd =  operand[7] & ~sum9[8];
        end else begin
            page_fwd = sum9[8];
            page_bwd = 1'b0;
        end
    end

endmodule : pcl_adder
`default_nettype wire

// File: rtl/pcl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pcl_sequencer
//  Description : 65c02 program-counter low byte. Loads, increments and adds
//                branch offsets to PCL; runs a four-phase carry/borrow
//                handshake with PCH on page crossings, with per-phase timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module pcl_sequencer
    import pc_pkg::*;
#(
    parameter logic [7:0] RESET_PCL  = RESET_PCL_DEFAULT,
    parameter int         HS_TIMEOUT = 4
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    pcl_sequencer_if.slave   bus
);

    localparam int              CNT_W    = $clog2(HS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HS_TIMEOUT - 1);

    pcl_state_t       state;
    logic [7:0]       pcl;
    logic [CNT_W-1:0] cnt;
    logic             carry_req;
    logic             borrow_req;
    logic             busy_r;
    logic             hs_err_r;

    logic [7:0]       add_operand;
    logic [7:0]       add_sum;
    logic             add_fwd;
    logic             add_bwd;

    // Branch has priority over increment; load bypasses the adder entirely
    assign add_operand = bus.branch_req ? bus.branch_offset : 8'h01;

    pcl_adder u_adder (
        .pcl       (pcl),
        .operand   (add_operand),
        .is_branch (bus.branch_req),
        .sum       (add_sum),
        .page_fwd  (add_fwd),
        .page_bwd  (add_bwd)
    );

    // PCL register, handshake FSM, phase timeout counter and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pcl        <= RESET_PCL;
            cnt        <= '0;
            carry_req  <= 1'b0;
            borrow_req <= 1'b0;
            busy_r     <= 1'b0;
            hs_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pcl_load) begin
                        pcl <= bus.db_in;
                    end else if (bus.branch_req || bus.inc_req) begin
                        pcl <= add_sum;
                        cnt <= '0;
                        if (add_fwd) begin
                            state     <= CARRY_REQ;
                            carry_req <= 1'b1;
                            busy_r    <= 1'b1;
                        end else if (add_bwd) begin
                            state      <= BORROW_REQ;
                            borrow_req <= 1'b1;
                            busy_r     <= 1'b1;
                        end
                    end
                end

                CARRY_REQ, BORROW_REQ: begin
                    // A load from decode still lands; inc/branch are dropped
                    if (bus.pcl_load) pcl <= bus.db_in;
                    if (bus.carry_done) begin
                        carry_req  <= 1'b0;
                        borrow_req <= 1'b0;
                        state      <= RELEASE;
                        cnt        <= '0;
                    end else if (cnt == CNT_LAST) begin
                        carry_req  <= 1'b0;
                        borrow_req <= 1'b0;
                        hs_err_r   <= 1'b1;
                        busy_r     <= 1'b0;
                        state      <= IDLE;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    if (bus.pcl_load) pcl <= bus.db_in;
                    if (!bus.carry_done) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        hs_err_r <= 1'b1;
                        busy_r   <= 1'b0;
                        state    <= IDLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    carry_req  <= 1'b0;
                    borrow_req <= 1'b0;
                    busy_r     <= 1'b0;
                    state      <= IDLE;
                    cnt        <= '0;
                end
            endcase
        end
    end

    assign bus.db_out          = pcl;
    assign bus.address_low_out = pcl;
    assign bus.carry_to_pch    = carry_req;
    assign bus.borrow_to_pch   = borrow_req;
    assign bus.busy            = busy_r;
    assign bus.hs_error        = hs_err_r;

endmodule : pcl_sequencer
`default_nettype wire
